// File: rtl/dds_pkg.sv
// ============================================================================
// dds_pkg : shared width helpers, slot tag type and phase-to-LUT address map
// Revision: 1.0
// ============================================================================
`default_nettype none

package dds_pkg;

   typedef logic [2:0] slot_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        neg;
   } lut_req_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Quarter mode folds the phase onto one quadrant: MSB gives the sign,
   // the next bit mirrors the index so the table is read back-to-front.
   function automatic lut_req_t phase_to_addr(input logic [31:0] acc,
                                              input int          pw,
                                              input int          aw,
                                              input bit          quarter);
      lut_req_t    r;
      logic [31:0] mask;
      logic [31:0] idx;
      mask  = (32'd1 << aw) - 32'd1;
      r.neg = 1'b0;
      if (quarter) begin
         idx = (acc >> (pw - 2 - aw)) & mask;
         if (((acc >> (pw - 2)) & 32'd1) != 32'd0) begin
            idx = ~idx & mask;
         end
         r.neg = ((acc >> (pw - 1)) & 32'd1) != 32'd0;
      end else begin
         idx = (acc >> (pw - aw)) & mask;
      end
      r.addr = idx;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dds_lut_ram.sv
// ============================================================================
// dds_lut_ram : DEPTH x WW waveform table, sync write, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module dds_lut_ram #(
   parameter int WW    = 6,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [WW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [WW-1:0] rd_data_o
);

   logic [WW-1:0] mem_q [DEPTH];
   logic [WW-1:0] rd_data_q;

   // Both accesses sit in one edge, so a colliding read sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/dds_multi_lut.sv
// ============================================================================
// dds_multi_lut : multi-channel DDS sharing one reprogrammable waveform LUT
// Revision: 1.0
// ============================================================================
`default_nettype none

module dds_multi_lut
   import dds_pkg::*;
#(
   parameter  int WW       = 6,
   parameter  int DEPTH    = 16,
   parameter  int CHANNELS = 2,
   parameter  int PW       = 12,
   parameter  int QUARTER  = 1,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = clog2_min1(CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run_i,
   input  logic                     phase_clr_i,
   input  logic                     lut_we_i,
   input  logic [AW-1:0]            lut_wa_i,
   input  logic [WW-1:0]            lut_wd_i,
   input  logic                     ftw_we_i,
   input  logic [CW-1:0]            ftw_ch_i,
   input  logic [PW-1:0]            ftw_wd_i,
   output logic [CHANNELS*WW-1:0]   sample_o,
   output logic                     frame_strobe_o
);

   localparam logic [WW-1:0] MAG_MASK = (QUARTER != 0) ? {1'b0, {(WW-1){1'b1}}}
                                                        : {WW{1'b1}};
   localparam logic [CW-1:0] LAST_SLOT = CW'(CHANNELS - 1);

   logic [CW-1:0] slot_q;
   logic [CW-1:0] slot_d;
   logic [PW-1:0] acc_q [CHANNELS];
   logic [PW-1:0] ftw_q [CHANNELS];

   logic          s1_vld_q;
   slot_t         s1_ch_q;
   logic          s1_neg_q;
   logic [AW-1:0] addr_q;
   logic          s2_vld_q;
   slot_t         s2_ch_q;
   logic          s2_neg_q;
   logic [WW-1:0] sample_q [CHANNELS];
   logic          frame_strobe_q;

   logic          w_issue;
   lut_req_t      w_req;
   logic [WW-1:0] w_rd_data;
   logic [WW-1:0] w_mag;
   logic [WW-1:0] w_val;

   assign w_issue = run_i & ~phase_clr_i;
   assign w_req   = phase_to_addr(32'(acc_q[slot_q]), PW, AW, QUARTER != 0);

   always_comb begin
      slot_d = slot_q;
      if (phase_clr_i) begin
         slot_d = '0;
      end else if (run_i) begin
         slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            acc_q[c] <= '0;
         end
      end else begin
         slot_q <= slot_d;
         if (phase_clr_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
               acc_q[c] <= '0;
            end
         end else if (run_i) begin
            acc_q[slot_q] <= acc_q[slot_q] + ftw_q[slot_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            ftw_q[c] <= '0;
         end
      end else if (ftw_we_i && (int'(ftw_ch_i) < CHANNELS)) begin
         ftw_q[ftw_ch_i] <= ftw_wd_i;
      end
   end

   // Three-stage read pipeline: address, LUT data, sample register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q       <= 1'b0;
         s1_ch_q        <= '0;
         s1_neg_q       <= 1'b0;
         addr_q         <= '0;
         s2_vld_q       <= 1'b0;
         s2_ch_q        <= '0;
         s2_neg_q       <= 1'b0;
         frame_strobe_q <= 1'b0;
      end else begin
         s1_vld_q       <= w_issue;
         s1_ch_q        <= slot_t'(slot_q);
         s1_neg_q       <= w_req.neg;
         addr_q         <= AW'(w_req.addr);
         s2_vld_q       <= s1_vld_q;
         s2_ch_q        <= s1_ch_q;
         s2_neg_q       <= s1_neg_q;
         frame_strobe_q <= s2_vld_q && (s2_ch_q == slot_t'(CHANNELS - 1));
      end
   end

   dds_lut_ram #(
      .WW    (WW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_lut (
      .clk       (clk),
      .wr_en_i   (lut_we_i),
      .wr_addr_i (lut_wa_i),
      .wr_data_i (lut_wd_i),
      .rd_addr_i (addr_q),
      .rd_data_o (w_rd_data)
   );

   // Full mode never raises neg and keeps every data bit, so one path serves both.
   assign w_mag = w_rd_data & MAG_MASK;
   assign w_val = s2_neg_q ? (~w_mag + WW'(1)) : w_mag;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      always_ff @(posedge clk) begin
         if (rst) begin
            sample_q[c] <= '0;
         end else if (s2_vld_q && (s2_ch_q == slot_t'(c))) begin
            sample_q[c] <= w_val;
         end
      end
      assign sample_o[c*WW +: WW] = sample_q[c];
   end

   assign frame_strobe_o = frame_strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_multi_lut.sv
// ============================================================================
// tb_dds_multi_lut : directed vector bench, quarter and full mode instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dds_multi_lut;

   typedef struct {
      int phase;
      int kind;
      int idx;
      int exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        phase_clr;
   logic        lut_we;
   logic [3:0]  lut_wa;
   logic [5:0]  lut_wd;
   logic        ftw_we;
   logic [0:0]  ftw_ch;
   logic [11:0] ftw_wd;
   logic [11:0] sample_q;
   logic [11:0] sample_f;
   logic        fs_q;
   logic        fs_f;

   int total = 0;
   int bad   = 0;
   int cap  [6][80];
   int strb [6][140];
   vec_t vt[$];

   always #5 clk = ~clk;

   dds_multi_lut u_dut_q (
      .clk            (clk),
      .rst            (rst),
      .run_i          (run),
      .phase_clr_i    (phase_clr),
      .lut_we_i       (lut_we),
      .lut_wa_i       (lut_wa),
      .lut_wd_i       (lut_wd),
      .ftw_we_i       (ftw_we),
      .ftw_ch_i       (ftw_ch),
      .ftw_wd_i       (ftw_wd),
      .sample_o       (sample_q),
      .frame_strobe_o (fs_q)
   );

   dds_multi_lut #(.QUARTER(0)) u_dut_f (
      .clk            (clk),
      .rst            (rst),
      .run_i          (run),
      .phase_clr_i    (phase_clr),
      .lut_we_i       (lut_we),
      .lut_wa_i       (lut_wa),
      .lut_wd_i       (lut_wd),
      .ftw_we_i       (ftw_we),
      .ftw_ch_i       (ftw_ch),
      .ftw_wd_i       (ftw_wd),
      .sample_o       (sample_f),
      .frame_strobe_o (fs_f)
   );

   function automatic int ch_q(input int c);
      logic [5:0] s;
      int v;
      s = sample_q[c*6 +: 6];
      v = $signed(s);
      return v;
   endfunction

   function automatic int ch_f(input int c);
      logic [5:0] s;
      s = sample_f[c*6 +: 6];
      return int'(s);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic prog_lut(input int mul);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         lut_we = 1'b1;
         lut_wa = 4'(i);
         lut_wd = 6'(mul * i);
      end
      @(negedge clk);
      lut_we = 1'b0;
   endtask

   task automatic prog_ftw(input int ch, input int v);
      @(negedge clk);
      ftw_we = 1'b1;
      ftw_ch = 1'(ch);
      ftw_wd = 12'(v);
      @(negedge clk);
      ftw_we = 1'b0;
   endtask

   task automatic clr_phase();
      @(negedge clk);
      phase_clr = 1'b1;
      @(negedge clk);
      phase_clr = 1'b0;
   endtask

   // Posedge n after run rises issues ch0 on odd n; ch0 sample k is visible after edge 3+2k.
   task automatic run_seq(input int ph, input int nk, input int wr_n);
      int nmax;
      nmax = 3 + 2 * (nk - 1);
      @(negedge clk);
      run = 1'b1;
      for (int n = 1; n <= nmax; n++) begin
         lut_we = (n == wr_n);
         lut_wa = 4'd3;
         lut_wd = 6'd7;
         @(posedge clk);
         #1;
         strb[ph][n] = (ph == 1) ? int'(fs_f) : int'(fs_q);
         if (n >= 3 && ((n - 3) % 2) == 0) begin
            cap[ph][(n - 3) / 2] = (ph == 1) ? ch_f(0) : ch_q(0);
         end
         @(negedge clk);
      end
      lut_we = 1'b0;
      run    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; phase_clr = 1'b0;
      lut_we = 1'b0; lut_wa = '0; lut_wd = '0;
      ftw_we = 1'b0; ftw_ch = '0; ftw_wd = '0;

      // {phase, kind(0=ch0 sample k, 1=strobe at edge n), idx, expected}
      vt.push_back('{0, 0,  0,   0}); vt.push_back('{0, 0,  1,   2});
      vt.push_back('{0, 0, 15,  30}); vt.push_back('{0, 0, 16,  30});
      vt.push_back('{0, 0, 17,  28}); vt.push_back('{0, 0, 31,   0});
      vt.push_back('{0, 0, 32,   0}); vt.push_back('{0, 0, 33,  -2});
      vt.push_back('{0, 0, 47, -30}); vt.push_back('{0, 0, 48, -30});
      vt.push_back('{0, 0, 62,  -2}); vt.push_back('{0, 0, 64,   0});
      vt.push_back('{0, 1,  3,   0}); vt.push_back('{0, 1,  4,   1});
      vt.push_back('{0, 1,  5,   0}); vt.push_back('{0, 1, 10,   1});
      vt.push_back('{1, 0,  0,   0}); vt.push_back('{1, 0,  1,   1});
      vt.push_back('{1, 0, 15,  15}); vt.push_back('{1, 0, 16,   0});
      vt.push_back('{1, 1,  4,   1}); vt.push_back('{1, 1,  5,   0});
      vt.push_back('{1, 1,  6,   1});
      vt.push_back('{2, 0,  1,   0}); vt.push_back('{2, 0, 64,   0});
      vt.push_back('{2, 0, 65,  -2});
      vt.push_back('{3, 0,  3,   6}); vt.push_back('{3, 0,  4,   8});
      vt.push_back('{3, 0, 28,   7});

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_sample_q", int'(sample_q), 0);
      check("reset_sample_f", int'(sample_f), 0);
      check("reset_strobe",   int'(fs_q | fs_f), 0);
      rst = 1'b0;

      // quarter-wave sweep
      prog_lut(2);
      prog_ftw(0, 64);
      prog_ftw(1, 0);
      clr_phase();
      run_seq(0, 65, 0);
      check("quarter_ch1_const", ch_q(1), 0);

      // full-period sweep
      prog_lut(1);
      prog_ftw(0, 256);
      clr_phase();
      run_seq(1, 17, 0);

      // negative tuning word wraps the accumulator downward
      prog_lut(2);
      prog_ftw(0, 4095);
      clr_phase();
      run_seq(2, 66, 0);

      // LUT[3] rewritten on the edge that registers its read data
      prog_ftw(0, 64);
      clr_phase();
      run_seq(3, 29, 8);

      foreach (vt[i]) begin
         if (vt[i].kind == 0) begin
            check($sformatf("ph%0d_sample_k%0d", vt[i].phase, vt[i].idx),
                  cap[vt[i].phase][vt[i].idx], vt[i].exp);
         end else begin
            check($sformatf("ph%0d_strobe_n%0d", vt[i].phase, vt[i].idx),
                  strb[vt[i].phase][vt[i].idx], vt[i].exp);
         end
      end

      // run dropped: last ch0 issue is k=6 -> LUT[6]=12, then frozen
      clr_phase();
      run_seq(4, 6, 0);
      repeat (3) @(posedge clk);
      for (int m = 0; m < 5; m++) begin
         @(posedge clk);
         #1;
         check($sformatf("frozen_strobe_%0d", m), int'(fs_q), 0);
         check($sformatf("frozen_ch0_%0d", m), ch_q(0), 12);
      end

      // phase_clr together with run: no issue on that edge, restart at acc 0
      @(negedge clk);
      run = 1'b1;
      phase_clr = 1'b1;
      @(negedge clk);
      phase_clr = 1'b0;
      for (int m = 0; m < 5; m++) begin
         @(posedge clk);
         #1;
         if (m == 2) begin
            check("clr_ch0_k0", ch_q(0), 0);
            check("clr_strobe_b2", int'(fs_q), 0);
         end
         if (m == 3) check("clr_strobe_b3", int'(fs_q), 1);
         if (m == 4) check("clr_ch0_k1", ch_q(0), 2);
      end

      // reset in the middle of a run
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      check("midrst_sample_q", int'(sample_q), 0);
      check("midrst_sample_f", int'(sample_f), 0);
      check("midrst_strobe",   int'(fs_q | fs_f), 0);
      prog_ftw(0, 64);
      run_seq(5, 3, 0);
      check("midrst_k1", cap[5][1], 2);
      check("midrst_k2", cap[5][2], 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dds_multi_lut.md
# dds_multi_lut

Multi-channel direct digital synthesis core built around a single run-time reprogrammable waveform LUT. Each channel owns a phase accumulator and frequency tuning word (FTW). A round-robin scheduler time-shares one registered LUT read port across channels. Optional quarter-wave mode reconstructs a full signed sine from a quarter table. Sits between the pin-level top (LUT/FTW programming via I/O) and the output mux driving `uo_out`.

## Interface
- `WW`, 6: sample width in bits (output is signed WW-bit in quarter mode, raw in full mode)
- `DEPTH`, 16: LUT entries; power of two, ≥ 4
- `CHANNELS`, 2: number of DDS channels; 1..8
- `PW`, 12: phase accumulator width; PW ≥ log2(DEPTH)+2
- `QUARTER`, 1: 1 = LUT holds quarter wave, 0 = LUT holds full period
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  enables slot issue; 0 freezes accumulators and scheduler
- `phase_clr`  in  1  synchronous clear of all accumulators and scheduler
- `lut_we`  in  1  LUT write strobe
- `lut_wa`  in  log2(DEPTH)  LUT write address
- `lut_wd`  in  WW  LUT write data
- `ftw_we`  in  1  FTW write strobe
- `ftw_ch`  in  log2(CHANNELS) (min 1)  FTW target channel
- `ftw_wd`  in  PW  FTW value
- `sample`  out  CHANNELS*WW  per-channel output, channel c at bits [c*WW +: WW]
- `frame_strobe`  out  1  one-cycle pulse when channel CHANNELS-1 output updates

## Operation
- Reset: `sample` = 0, `frame_strobe` = 0, all accumulators = 0, all FTWs = 0, scheduler slot = 0, pipeline valids = 0. LUT contents not reset.
- Scheduler: slot counter 0..CHANNELS-1, advances by 1 per cycle while `run`=1, wraps to 0; holds when `run`=0. In-flight pipeline entries always complete.
- Issue (run=1, slot c): addr derived from current acc[c]; acc[c] ← acc[c] + ftw[c] mod 2^PW.
- Full mode (QUARTER=0): addr = acc[PW-1 -: log2(DEPTH)]; output = LUT word unchanged.
- Quarter mode: sign = acc[PW-1], mirror = acc[PW-2], idx = acc[PW-3 -: log2(DEPTH)]; addr = mirror ? ~idx : idx; mag = LUT word low WW-1 bits (MSB ignored); output = sign ? -mag : +mag (two's complement, WW bits).
- FTW write: ftw[ftw_ch] ← ftw_wd; used from that channel's next issue. `ftw_ch` ≥ CHANNELS ignored.
- LUT write/read same address same cycle: read returns old word (read-before-write).
- `phase_clr`: all acc ← 0, slot ← 0 at that edge; FTWs, LUT, `sample` untouched; in-flight entries still complete. `phase_clr` takes priority over issue in the same cycle (no accumulate).
- `rst` overrides everything including in-flight entries.

## Timing
- Issue in cycle t → addr register at edge end of t → LUT data register at end of t+1 → `sample[c]` updated at end of t+2, visible cycle t+3. Latency 3 edges.
- `frame_strobe` registered with the channel CHANNELS-1 update; high exactly that cycle.
- Continuous run: each channel updates once every CHANNELS cycles; one `frame_strobe` per CHANNELS cycles.
- CHANNELS=1: updates every cycle, `frame_strobe` every cycle after fill.

## Structure
- Package `dds_pkg`: clog2-safe width constant helpers, `phase_to_addr` function (quarter/full address + sign extraction), slot index typedef.
- Sub-module `dds_lut_ram`: DEPTH×WW, one sync write port, one registered read port, read-before-write.
- Top holds scheduler, accumulator/FTW arrays, 3-stage pipeline with channel tag and valid.

## Test plan
- Reset: assert `rst` 2 cycles mid-run → `sample`=0, `frame_strobe`=0, next run from acc=0 on all channels.
- Quarter mode (defaults): LUT[i]=2i, ftw[0]=64, ftw[1]=0, run → ch0 sequence 0,2,…,30,30,28,…,0,0,-2,…,-30,-30,…,-2, then repeat; ch1 constant 0.
- Full mode (QUARTER=0): LUT[i]=i, ftw[0]=256 → ch0 0,1,…,15,0; `frame_strobe` every 2 cycles.
- FTW wrap: ftw[0]=4095 (−1) → acc 0,4095,4094…; quarter output first two samples 0 then -(LUT[0]&31)=-(0) with LUT[15]-indexed negative lobe verified per model.
- LUT collision: write LUT[3]=7 in the read cycle of addr 3 (old 6) → sample shows 6; next revisit shows 7.
- `run` toggle and `phase_clr`: drop run 5 cycles → `sample` frozen after drain, no strobes; `phase_clr` with run=1 → next issued channel 0 at acc 0, output LUT[0].
